aes_round_sequencer: RTL

- Iterative AES encryption engine: one registered state, one middle-round datapath instance (aes_round_param LAST=0) and one final-round instance (aes_round_param LAST=1), run for NR+1 key additions per block.
- Sequences the round counter, drives the round-key index into an external expanded-key store and exposes valid/ready handshakes on both sides.
- Sits between the block-level mode logic (ECB/CTR wrappers) and the key-expansion storage.

---
 rtl/aes_round_sequencer_if.sv | 36 +++
 rtl/aes_round_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_sequencer_if
//  Description : Handshake and bus bundle for the iterative AES engine.
//                master = block-level mode logic plus key store side,
//                slave  = aes_round_sequencer.
//  Signals     : din_block/din_valid/din_ready   plaintext input handshake
//                round_key_idx/round_key         expanded-key store read
//                dout_block/dout_valid/dout_ready ciphertext output handshake
//                busy                            engine in ROUND or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_sequencer_if;
  localparam int BLOCK_W = 128;

  logic [BLOCK_W-1:0] din_block;
  logic               din_valid;
  logic               din_ready;
  logic [3:0]         round_key_idx;
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] dout_block;
  logic               dout_valid;
  logic               dout_ready;
  logic               busy;

  modport master (
    output din_block, din_valid, round_key, dout_ready,
    input  din_ready, round_key_idx, dout_block, dout_valid, busy
  );

  modport slave (
    input  din_block, din_valid, round_key, dout_ready,
    output din_ready, round_key_idx, dout_block, dout_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_param
//  Description : One combinational AES encryption round:
//                SubBytes -> ShiftRows -> MixColumns (skipped when LAST=1)
//                -> AddRoundKey. Byte 0 of the block is bits [127:120];
//                byte index 4*c + r is row r of column c.
//  Ports       : i_state  128  round input state
//                i_key    128  round key
//                o_state  128  round output state
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_param #(
  parameter bit LAST = 1'b0
) (
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  output logic [127:0] o_state
);

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed algebraically: multiplicative inverse as x^254 (which
  // maps 0 to 0 as required), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign sb[b] = sbox(i_state[127-8*b -: 8]);
  end

  // Row r rotates left by r positions across the four columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  if (LAST) begin : g_final
    for (genvar b = 0; b < 16; b++) begin : g_pass
      assign mc[b] = sr[b];
    end
  end else begin : g_mix
    for (genvar c = 0; c < 4; c++) begin : g_mix_col
      assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                       ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                       ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                       ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1]
                       ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  for (genvar b = 0; b < 16; b++) begin : g_ark
    assign o_state[127-8*b -: 8] = mc[b] ^ i_key[127-8*b -: 8];
  end

endmodule

// ============================================================================
//  Module      : aes_round_sequencer
//  Description : Iterative AES encryption engine. One state register, one
//                middle-round and one final-round datapath; the round
//                counter drives the key index into an external expanded-key
//                store that answers combinationally in the same cycle.
//  Ports       : clk    system clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    aes_round_sequencer_if.slave (din/key/dout/busy)
//  Parameters  : NR     number of rounds, 10/12/14 (AES-128/192/256)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_round_sequencer_if.slave  bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e       fsm_q,        fsm_d;
  logic [3:0]   rnd_q,        rnd_d;
  logic [127:0] blk_q,        blk_d;
  logic         din_ready_q,  din_ready_d;
  logic         dout_valid_q, dout_valid_d;
  logic         busy_q,       busy_d;
  logic [3:0]   key_idx_q,    key_idx_d;

  logic [127:0] mid_out;
  logic [127:0] last_out;
  logic [127:0] round_out;

  aes_round_param #(.LAST(1'b0)) u_mid_round (
    .i_state (blk_q),
    .i_key   (bus.round_key),
    .o_state (mid_out)
  );

  aes_round_param #(.LAST(1'b1)) u_last_round (
    .i_state (blk_q),
    .i_key   (bus.round_key),
    .o_state (last_out)
  );

  assign round_out = (rnd_q == NR_IDX) ? last_out : mid_out;

  // The key index is registered alongside the counter so it already points
  // at the key for the round being computed when that cycle begins.
  always_comb begin
    fsm_d        = fsm_q;
    rnd_d        = rnd_q;
    blk_d        = blk_q;
    din_ready_d  = din_ready_q;
    dout_valid_d = dout_valid_q;
    busy_d       = busy_q;
    key_idx_d    = key_idx_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.din_valid && din_ready_q) begin
          blk_d       = bus.din_block ^ bus.round_key;
          rnd_d       = 4'd1;
          key_idx_d   = 4'd1;
          fsm_d       = ST_ROUND;
          din_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_ROUND: begin
        blk_d = round_out;
        if (rnd_q == NR_IDX) begin
          // Counter parks at NR; it is cleared on the output handshake.
          fsm_d        = ST_DONE;
          dout_valid_d = 1'b1;
          key_idx_d    = 4'd0;
        end else begin
          rnd_d     = rnd_q + 4'd1;
          key_idx_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.dout_ready) begin
          fsm_d        = ST_IDLE;
          rnd_d        = 4'd0;
          dout_valid_d = 1'b0;
          busy_d       = 1'b0;
          din_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d        = ST_IDLE;
        rnd_d        = 4'd0;
        dout_valid_d = 1'b0;
        busy_d       = 1'b0;
        din_ready_d  = 1'b1;
        key_idx_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      rnd_q        <= 4'd0;
      blk_q        <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      key_idx_q    <= 4'd0;
    end else begin
      fsm_q        <= fsm_d;
      rnd_q        <= rnd_d;
      blk_q        <= blk_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      key_idx_q    <= key_idx_d;
    end
  end

  assign bus.din_ready     = din_ready_q;
  assign bus.dout_valid    = dout_valid_q;
  assign bus.busy          = busy_q;
  assign bus.round_key_idx = key_idx_q;
  // Intermediate round states never leave the engine.
  assign bus.dout_block    = (fsm_q == ST_DONE) ? blk_q : '0;

endmodule
`default_nettype wire
